// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one mem_unit between NUM_REQ
// requesters. The granted request is muxed onto the memory port, and reads
// are tracked through a LATENCY-deep {valid, id} pipeline so that the
// read-valid strobe returns to the requester that issued the read.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i, lock_i       per-requester request / lock request
//   w_en_i              per-requester write enable
//   addr_i, w_data_i,   packed per-requester address, write data and
//   b_en_i              byte enables (requester k uses slice k)
//   gnt_o               one-hot grant, combinational
//   r_valid_o, r_data_o one-hot read-valid strobe, broadcast read data
//   mem_*_o             request fields towards mem_unit
//   mem_r_data_i        read data from mem_unit
//
// Build option: MEM_ARB_LOCK_EN enables locked grants bounded by MAX_LOCK.
// Without it lock_i is ignored and arbitration is pure round-robin.

module mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_WORDS  = 64,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int LATENCY    = 1,
  parameter int MAX_LOCK   = 4,
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS),
  localparam int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              lock_i,
  input  logic [NUM_REQ-1:0]              w_en_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   w_data_i,
  input  logic [NUM_REQ*NUM_BYTES-1:0]    b_en_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              r_valid_o,
  output logic [DATA_WIDTH-1:0]           r_data_o,
  output logic                            mem_req_o,
  output logic                            mem_w_en_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0]           mem_w_data_o,
  output logic [NUM_BYTES-1:0]            mem_b_en_o,
  input  logic [DATA_WIDTH-1:0]           mem_r_data_i
);

  localparam int CW = ID_WIDTH + 1;

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] rr_idx, gnt_idx, gnt_next;
  logic                rr_vld, gnt_vld;
  logic [CW-1:0]       cand;

  // Walk from the far end back towards ptr so the lowest offset wins.
  always_comb begin
    rr_idx = '0;
    rr_vld = 1'b0;
    cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (req_i[cand[ID_WIDTH-1:0]]) begin
        rr_vld = 1'b1;
        rr_idx = cand[ID_WIDTH-1:0];
      end
    end
  end

  assign gnt_next = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);

`ifdef MEM_ARB_LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK + 1);

  logic                locked_q, locked_d;
  logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;
  logic [LCW-1:0]      lock_cnt_q, lock_cnt_d, lock_cnt_inc;
  logic                lock_hold;

  // A lock only carries over while the owner keeps requesting.
  assign lock_hold = locked_q & req_i[lock_id_q];
  assign gnt_idx   = lock_hold ? lock_id_q : rr_idx;
  assign gnt_vld   = ~rst_i & (lock_hold | rr_vld);

  // lock_cnt counts consecutive grants to the owner; the grant that would
  // reach MAX_LOCK releases the lock and rotation resumes from owner+1.
  always_comb begin
    ptr_d        = ptr_q;
    locked_d     = 1'b0;
    lock_id_d    = lock_id_q;
    lock_cnt_d   = '0;
    lock_cnt_inc = (lock_hold ? lock_cnt_q : '0) + LCW'(1);
    if (gnt_vld) begin
      if (lock_i[gnt_idx] && (lock_cnt_inc < LCW'(MAX_LOCK))) begin
        locked_d   = 1'b1;
        lock_id_d  = gnt_idx;
        lock_cnt_d = lock_cnt_inc;
      end else begin
        ptr_d = gnt_next;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked_q   <= 1'b0;
      lock_id_q  <= '0;
      lock_cnt_q <= '0;
    end else begin
      locked_q   <= locked_d;
      lock_id_q  <= lock_id_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  localparam int unused_max_lock = MAX_LOCK;
  logic unused_lock;

  assign unused_lock = ^lock_i;
  assign gnt_idx     = rr_idx;
  assign gnt_vld     = ~rst_i & rr_vld;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = gnt_next;
  end
`endif

  always_comb begin
    gnt_o        = '0;
    mem_req_o    = 1'b0;
    mem_w_en_o   = 1'b0;
    mem_addr_o   = '0;
    mem_w_data_o = '0;
    mem_b_en_o   = '0;
    if (gnt_vld) begin
      gnt_o[gnt_idx] = 1'b1;
      mem_req_o      = 1'b1;
      mem_w_en_o     = w_en_i[gnt_idx];
      mem_addr_o     = addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_w_data_o   = w_data_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      mem_b_en_o     = b_en_i[int'(gnt_idx)*NUM_BYTES +: NUM_BYTES];
    end
  end

  logic [LATENCY-1:0]  pipe_vld_q;
  logic [ID_WIDTH-1:0] pipe_id_q [LATENCY];

  // Ids need no reset: they are only looked at behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      pipe_vld_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      pipe_vld_q[0] <= gnt_vld & ~mem_w_en_o;
      pipe_id_q[0]  <= gnt_idx;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_id_q[s]  <= pipe_id_q[s-1];
      end
    end
  end

  always_comb begin
    r_valid_o = '0;
    if (pipe_vld_q[LATENCY-1] && !rst_i) r_valid_o[pipe_id_q[LATENCY-1]] = 1'b1;
  end

  assign r_data_o = mem_r_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int N    = 4;
  localparam int NW   = 64;
  localparam int DW   = 32;
  localparam int NB   = 4;
  localparam int AW   = 6;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req, lock, w_en;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*NB-1:0] ben;

  logic [N-1:0]  gnt1, gnt3, rv1, rv3;
  logic [DW-1:0] rd1, rd3, mrd1, mrd3, mwd1, mwd3;
  logic          mreq1, mreq3, mwen1, mwen3;
  logic [AW-1:0] maddr1, maddr3;
  logic [NB-1:0] mben1, mben3;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .NUM_WORDS(NW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                .LATENCY(1), .MAX_LOCK(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .w_en_i(w_en),
    .addr_i(addr), .w_data_i(wdata), .b_en_i(ben), .gnt_o(gnt1),
    .r_valid_o(rv1), .r_data_o(rd1), .mem_req_o(mreq1), .mem_w_en_o(mwen1),
    .mem_addr_o(maddr1), .mem_w_data_o(mwd1), .mem_b_en_o(mben1),
    .mem_r_data_i(mrd1));

  mem_arbiter #(.NUM_REQ(N), .NUM_WORDS(NW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                .LATENCY(3), .MAX_LOCK(4)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .w_en_i(w_en),
    .addr_i(addr), .w_data_i(wdata), .b_en_i(ben), .gnt_o(gnt3),
    .r_valid_o(rv3), .r_data_o(rd3), .mem_req_o(mreq3), .mem_w_en_o(mwen3),
    .mem_addr_o(maddr3), .mem_w_data_o(mwd3), .mem_b_en_o(mben3),
    .mem_r_data_i(mrd3));

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // mem_unit stand-ins, one per DUT latency
  logic [DW-1:0] env1 [NW];
  logic [DW-1:0] env3 [NW];
  logic [DW-1:0] rp1;
  logic [DW-1:0] rp3 [3];

  always @(posedge clk) begin
    if (mreq1 && mwen1) env1[maddr1] <= merge(env1[maddr1], mwd1, mben1);
    rp1 <= (mreq1 && !mwen1) ? env1[maddr1] : '0;
    if (mreq3 && mwen3) env3[maddr3] <= merge(env3[maddr3], mwd3, mben3);
    rp3[0] <= (mreq3 && !mwen3) ? env3[maddr3] : '0;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign mrd1 = rp1;
  assign mrd3 = rp3[2];

  // reference model state
  int checks, errors, t, ptr_m, last_rst;
  bit model_on;
  logic [DW-1:0] golden [NW];
  bit            hist_rd   [HMAX];
  int            hist_id   [HMAX];
  logic [DW-1:0] hist_data [HMAX];

  // requester agents
  logic [N-1:0]  pend;
  logic          op_we   [N];
  logic [AW-1:0] op_addr [N];
  logic [DW-1:0] op_data [N];
  logic [NB-1:0] op_ben  [N];

  logic [N-1:0]  last_gnt1, last_rv1, last_rv3;
  logic [DW-1:0] last_rd1, last_rd3;

  logic [3:0] rot_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`ifdef MEM_ARB_LOCK_EN
  logic [3:0] lock_exp [7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
`else
  logic [3:0] lock_exp [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
`endif

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, t, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NB-1:0] b);
    op_we[i] = we; op_addr[i] = a; op_data[i] = d; op_ben[i] = b;
  endtask

  task automatic drive();
    req = pend;
    for (int i = 0; i < N; i++) begin
      w_en[i]            = op_we[i];
      addr[i*AW +: AW]   = op_addr[i];
      wdata[i*DW +: DW]  = op_data[i];
      ben[i*NB +: NB]    = op_ben[i];
    end
  endtask

  task automatic sample();
    int k;
    logic [N-1:0] eg;
    @(negedge clk);
    if (t >= HMAX) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", t, HMAX);
      $fatal(1, "cycle budget exceeded");
    end
    k  = -1;
    eg = '0;
    if (rst) begin
      last_rst = t;
      ptr_m    = 0;
      chk("rst_gnt", {gnt3, gnt1}, '0);
      chk("rst_mem_req", {mreq3, mreq1}, '0);
      chk("rst_rvalid", {rv3, rv1}, '0);
    end else begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (ptr_m + i) % N;
        if (k < 0 && req[c[1:0]]) k = c;
      end
      if (k >= 0) eg = N'(1) << k;
      if (model_on) begin
        chk("gnt_l1", gnt1, eg);
        chk("gnt_l3", gnt3, eg);
        chk("mem_req", {mreq3, mreq1}, {2{k >= 0}});
        if (k >= 0) begin
          chk("mem_fields_l1", {mwen1, maddr1, mben1, mwd1}, {op_we[k], op_addr[k], op_ben[k], op_data[k]});
          chk("mem_fields_l3", {mwen3, maddr3, mben3, mwd3}, {op_we[k], op_addr[k], op_ben[k], op_data[k]});
        end else begin
          chk("mem_idle", {mwen1, maddr1, mben1, mwd1, mwen3, maddr3, mben3, mwd3}, '0);
        end
      end
    end
    for (int j = 0; j < 2; j++) begin
      int L, g;
      logic [N-1:0] erv, arv;
      logic [DW-1:0] ard;
      string nv, nd;
      L   = (j == 0) ? 1 : 3;
      g   = t - L;
      erv = '0;
      if (!rst && g >= 0 && hist_rd[g] && last_rst < g) erv = N'(1) << hist_id[g];
      arv = (j == 0) ? rv1 : rv3;
      ard = (j == 0) ? rd1 : rd3;
      nv  = (j == 0) ? "rvalid_l1" : "rvalid_l3";
      nd  = (j == 0) ? "rdata_l1" : "rdata_l3";
      chk(nv, arv, erv);
      if (erv != '0) chk(nd, ard, hist_data[g]);
    end
    chk("rdata_pass", {rd3, rd1}, {mrd3, mrd1});
    hist_rd[t] = 1'b0;
    if (k >= 0) begin
      ptr_m   = (k + 1) % N;
      pend[k] = 1'b0;
      if (op_we[k]) golden[op_addr[k]] = merge(golden[op_addr[k]], op_data[k], op_ben[k]);
      else begin
        hist_rd[t]   = 1'b1;
        hist_id[t]   = k;
        hist_data[t] = golden[op_addr[k]];
      end
    end
    last_gnt1 = gnt1; last_rv1 = rv1; last_rv3 = rv3; last_rd1 = rd1; last_rd3 = rd3;
    t++;
  endtask

  task automatic cyc();
    drive();
    sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; t = 0; ptr_m = 0; last_rst = -1; model_on = 1'b1;
    rst = 1'b1; pend = '0; lock = '0;
    for (int i = 0; i < NW; i++) golden[i] = '0;
    for (int i = 0; i < N; i++) set_op(i, 1'b1, '0, '0, '0);
    cyc(); cyc();
    chk("reset_gnt_lit", last_gnt1, 4'b0000);
    rst = 1'b0;

    // rotation with all requesters active
    for (int i = 0; i < N; i++) set_op(i, 1'b1, AW'(10 + i), 32'h1000 + i, 4'hF);
    for (int c = 0; c < 8; c++) begin
      pend = '1;
      cyc();
      chk("rotation", last_gnt1, rot_exp[c % 4]);
    end
    pend = '0;
    repeat (4) cyc();

    // read routing
    set_op(0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
    pend = 4'b0001; cyc();
    chk("route_wr_gnt", last_gnt1, 4'b0001);
    set_op(2, 1'b0, 6'd5, '0, '0);
    pend = 4'b0100; cyc();
    chk("route_rd_gnt", last_gnt1, 4'b0100);
    pend = '0; cyc();
    chk("route_rv_l1", last_rv1, 4'b0100);
    chk("route_rd_l1", last_rd1, 32'hDEADBEEF);
    chk("route_rv_l3_early", last_rv3, 4'b0000);
    cyc();
    chk("route_rv_l3_early", last_rv3, 4'b0000);
    cyc();
    chk("route_rv_l3", last_rv3, 4'b0100);
    chk("route_rd_l3", last_rd3, 32'hDEADBEEF);

    // skip idle requesters and wrap
    rst = 1'b1; cyc(); rst = 1'b0;
    set_op(0, 1'b1, 6'd20, '0, '0);
    pend = 4'b0001; cyc();
    chk("skip_first", last_gnt1, 4'b0001);
    set_op(3, 1'b1, 6'd21, '0, '0);
    pend = 4'b1000; cyc();
    chk("skip_gnt3", last_gnt1, 4'b1000);
    set_op(0, 1'b1, 6'd22, '0, '0);
    pend = 4'b0001; cyc();
    chk("skip_wrap", last_gnt1, 4'b0001);

    // reset while a read is in flight
    set_op(1, 1'b0, 6'd5, '0, '0);
    pend = 4'b0010; cyc();
    chk("mid_rd_gnt", last_gnt1, 4'b0010);
    rst = 1'b1; pend = '0; cyc(); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("mid_no_rvalid", {last_rv3, last_rv1}, 8'h00);
    end
    for (int i = 0; i < N; i++) set_op(i, 1'b1, AW'(30 + i), '0, '0);
    pend = '1; cyc();
    chk("mid_ptr_zero", last_gnt1, 4'b0001);
    pend = '0; cyc();

    // requester 1 holds a lock while everyone requests
    rst = 1'b1; cyc(); rst = 1'b0;
    model_on = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 1'b1, AW'(40 + i), 32'hFFFF_FFFF, '0);
    lock = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      pend = '1;
      cyc();
      chk("lock_seq", last_gnt1, lock_exp[c]);
    end
    lock = '0; pend = '0;
    rst = 1'b1; cyc(); rst = 1'b0;
    model_on = 1'b1;

    // interleaved fill of every address, then random mixed traffic
    begin
      int na, budget;
      na = 0; budget = 0;
      while ((na < NW || pend != '0) && budget < 1000) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && na < NW && $urandom_range(0, 3) != 0) begin
            set_op(i, 1'b1, AW'(na), $urandom, 4'hF);
            pend[i] = 1'b1;
            na++;
          end
        end
`ifndef MEM_ARB_LOCK_EN
        lock = N'($urandom);
`endif
        cyc();
        budget++;
      end
      chk("fill_complete", {31'd0, (na == NW && pend == '0)}, 32'd1);
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          set_op(i, ($urandom_range(0, 9) >= 7), AW'($urandom_range(0, NW - 1)), $urandom, NB'($urandom));
          pend[i] = 1'b1;
        end
      end
`ifndef MEM_ARB_LOCK_EN
      lock = N'($urandom);
`endif
      cyc();
    end
    lock = '0; pend = '0;
    repeat (5) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one `mem_unit` instance between `NUM_REQ` requesters. It multiplexes each granted request onto the memory port and tracks in-flight reads through a `LATENCY`-deep pipeline. When read data returns, it steers a read-valid strobe back to the requester that issued the read. It sits directly in front of `mem_unit`, with requesters such as cores or DMA engines on its upstream side.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `NUM_WORDS`, 64: memory depth, must match `mem_unit`.
- `DATA_WIDTH`, 32: word width.
- `BYTE_WIDTH`, 8: byte width.
- `LATENCY`, 1: `mem_unit` read latency in cycles, ≥1.
- `MAX_LOCK`, 4: maximum consecutive locked grants; used only with `MEM_ARB_LOCK_EN`.
- Derived, do not override: `ADDR_WIDTH` = `$clog2(NUM_WORDS)`; `NUM_BYTES` = `DATA_WIDTH/BYTE_WIDTH`; `ID_WIDTH` = `$clog2(NUM_REQ)`.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_i`  in  NUM_REQ  per-requester request.
- `lock_i`  in  NUM_REQ  per-requester lock request; ignored without `MEM_ARB_LOCK_EN`.
- `w_en_i`  in  NUM_REQ  per-requester write enable.
- `addr_i`  in  NUM_REQ×ADDR_WIDTH  packed addresses; requester k uses slice k.
- `w_data_i`  in  NUM_REQ×DATA_WIDTH  packed write data.
- `b_en_i`  in  NUM_REQ×NUM_BYTES  packed byte enables.
- `gnt_o`  out  NUM_REQ  one-hot grant, combinational, same cycle as the request.
- `r_valid_o`  out  NUM_REQ  one-hot read-data-valid strobe.
- `r_data_o`  out  DATA_WIDTH  read data, broadcast to all requesters.
- `mem_req_o`, `mem_w_en_o`, `mem_addr_o`, `mem_w_data_o`, `mem_b_en_o`  out  memory-side request fields, same widths as a single requester's fields.
- `mem_r_data_i`  in  DATA_WIDTH  memory read data.

## Operation
- **Pointer.** Registered round-robin pointer `ptr` (ID_WIDTH bits); reset value 0.
- **Grant selection.**
  - Search `req_i` starting at index `ptr` and wrapping modulo `NUM_REQ`.
  - The first set bit k gets `gnt_o[k]` = 1.
  - If no requests are pending, `gnt_o` = 0.
- **Pointer update.** On a grant to k, `ptr` ← (k+1) mod `NUM_REQ` at the next edge. With no grant, `ptr` holds.
- **Memory side.**
  - `mem_req_o` = |`gnt_o`.
  - `mem_w_en_o`, `mem_addr_o`, `mem_w_data_o` and `mem_b_en_o` come from the granted slice.
  - With no grant, all memory-side fields drive 0.
- **Read tracking.**
  - Each cycle, a `LATENCY`-stage shift pipeline of {valid, id} is pushed.
  - valid = grant AND NOT `w_en`.
  - id = granted index.
- **Read return.**
  - When the last pipeline stage is valid, `r_valid_o[id]` = 1.
  - `r_data_o` = `mem_r_data_i` every cycle, unqualified.
- **Writes.** Writes complete on the grant cycle and produce no `r_valid_o`.
- **Back-to-back requests.** A new grant may issue every cycle, independent of in-flight reads; the pipeline is fully pipelined.
- **Requester obligation.** A requester must hold `req_i` and its fields until it sees `gnt_o`.

## Timing
- **Reset, with `rst_i` = 1 at an edge:**
  - `ptr` ← 0, all pipeline stages invalid, lock counter ← 0.
  - While `rst_i` is high, `gnt_o`, `mem_req_o` and `r_valid_o` are forced to 0.
  - `r_data_o` follows `mem_r_data_i`.
- **Grant latency.** 0 cycles, combinational from `req_i` and `ptr`.
- **Read response.** `r_valid_o` rises exactly `LATENCY` cycles after the grant edge.
  - Example: LATENCY = 1, grant in cycle n gives `r_valid_o` in cycle n+1.
- **Reset mid-operation.** In-flight reads are discarded. No `r_valid_o` is issued for them after reset deasserts.
- **Wrap-around.** With `ptr` = `NUM_REQ`−1 and a grant to `NUM_REQ`−1, `ptr` ← 0.
- **Simultaneous requests.** When all requesters assert every cycle, grants rotate 0, 1, 2, …, `NUM_REQ`−1, 0, … with one grant per cycle.

## Configuration
- **Macro:** `MEM_ARB_LOCK_EN`.
- **Defined:**
  - If the current grantee k asserts `req_i[k]` and `lock_i[k]`, the next grant stays with k and `ptr` is not advanced.
  - A lock counter counts consecutive locked grants.
  - When the counter reaches `MAX_LOCK`, the lock is overridden: normal rotation from k+1 applies and the counter clears.
  - The counter also clears whenever the grant changes or `req_i[k]` drops.
- **Undefined:** `lock_i` is ignored, no lock counter is built, and arbitration is pure round-robin.

## Test plan
- **Rotation.** NUM_REQ=4, all `req_i`=4'b1111 held for 8 cycles after reset → `gnt_o` = 0001, 0010, 0100, 1000, 0001, … with one grant per cycle.
- **Read routing.** Requester 0 writes 0xDEADBEEF to addr 5, then requester 2 reads addr 5 → with LATENCY=1, `r_valid_o`=0100 one cycle after the read grant and `r_data_o`=0xDEADBEEF. Repeat with LATENCY=3 → valid exactly 3 cycles after the grant.
- **Skip idle.** `ptr`=1 and only `req_i`[3] set → `gnt_o`=1000 and next `ptr`=0. Then only `req_i`[0] set → `gnt_o`=0001.
- **Reset mid-flight.** LATENCY=3, read granted, `rst_i` pulsed one cycle later → no `r_valid_o` for 5 cycles, and `ptr`=0 afterwards.
- **Interleaved traffic.** All 4 requesters interleave writes to distinct addresses 0..63, then read them back → every read matches a golden model and every `r_valid_o` is one-hot to the issuer.
- **Lock (with `MEM_ARB_LOCK_EN`, MAX_LOCK=4).** Requester 1 holds `req_i`+`lock_i` while requesters 0, 2 and 3 request → 4 consecutive grants to 1, then a grant to 2. Without the macro, the same stimulus rotates normally.
